// File: rtl/marker_track.sv
// rtl/marker_track.sv - 2-D colour-marker detector with frame tracking and draw mask
// A SIZE x SIZE square is found with a horizontal run counter plus one vertical run counter per column.
module marker_track #(
    parameter int SIZE        = 10,
    parameter int TOL         = 8,
    parameter int MAX_W       = 1920,
    parameter int INIT_X      = 10,
    parameter int INIT_Y      = 100,
    parameter int LOST_FRAMES = 4,
    parameter int BORDER      = 2,
    parameter int FILL        = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] video_in_data,
    input  logic        video_in_valid,
    input  logic        video_in_eop,
    input  logic [15:0] cnt_x,
    input  logic [15:0] cnt_y,
    input  logic [23:0] target_rgb,
    input  logic        enable,
    output logic        det_draw,
    output logic [15:0] pos_x,
    output logic [15:0] pos_y,
    output logic        pos_valid,
    output logic        hit_pulse
);

    localparam int AW = (MAX_W > 1) ? $clog2(MAX_W) : 1;
    localparam int MW = (LOST_FRAMES > 0) ? $clog2(LOST_FRAMES + 1) : 1;

    localparam logic [15:0]   MAX_W16  = 16'(MAX_W);
    localparam logic [4:0]    SIZE5    = 5'(SIZE);
    localparam logic [5:0]    SIZE6    = 6'(SIZE);
    localparam logic [7:0]    TOL8     = 8'(TOL);
    localparam logic [MW-1:0] LOST_M   = MW'(LOST_FRAMES);
    localparam logic [17:0]   OUT_OFF  = 18'(SIZE - 1 + BORDER);
    localparam logic [17:0]   IN_OFF   = 18'(SIZE - 1);
    localparam logic [17:0]   BORD18   = 18'(BORDER);

    function automatic logic [7:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    logic [4:0]    r_h_run;
    logic [4:0]    r_v_run [0:MAX_W-1];
    logic          r_frame_ok;
    logic          r_hit_flag;
    logic [15:0]   r_cand_x;
    logic [15:0]   r_cand_y;
    logic [MW-1:0] r_miss;
    logic [15:0]   r_pos_x;
    logic [15:0]   r_pos_y;
    logic          r_pos_valid;
    logic          r_hit_pulse;
    logic          r_det_draw;

    logic          w_in_range;
    logic          w_match;
    logic [5:0]    w_h_inc;
    logic [4:0]    w_h_next;
    logic          w_h_ok;
    logic [AW-1:0] w_addr;
    logic [4:0]    w_v_rd;
    logic [5:0]    w_v_inc;
    logic [4:0]    w_v_next;
    logic          w_hit;
    logic          w_first_hit;
    logic          w_eop;
    logic          w_frame_hit;
    logic [MW-1:0] w_miss_next;
    logic [17:0]   w_x18;
    logic [17:0]   w_y18;
    logic [17:0]   w_px18;
    logic [17:0]   w_py18;
    logic          w_outer;
    logic          w_inner;
    logic          w_draw;

    assign w_in_range = (cnt_x < MAX_W16);
    assign w_match    = video_in_valid & enable & w_in_range
                      & (abs_diff(video_in_data[23:16], target_rgb[23:16]) <= TOL8)
                      & (abs_diff(video_in_data[15:8],  target_rgb[15:8])  <= TOL8)
                      & (abs_diff(video_in_data[7:0],   target_rgb[7:0])   <= TOL8);

    assign w_h_inc  = {1'b0, r_h_run} + 6'd1;
    assign w_h_next = !w_match        ? 5'd0 :
                      (cnt_x == 16'd0) ? 5'd1 :
                      (w_h_inc >= SIZE6) ? SIZE5 : w_h_inc[4:0];
    assign w_h_ok   = w_match & (w_h_next == SIZE5);

    // Row 0 reads as empty so the column counters never need an explicit per-frame clear;
    // r_frame_ok hides stale counters until a frame is seen from its first pixel after reset.
    assign w_addr   = cnt_x[AW-1:0];
    assign w_v_rd   = (w_in_range & (cnt_y != 16'd0) & r_frame_ok) ? r_v_run[w_addr] : 5'd0;
    assign w_v_inc  = {1'b0, w_v_rd} + 6'd1;
    assign w_v_next = !w_h_ok ? 5'd0 : ((w_v_inc >= SIZE6) ? SIZE5 : w_v_inc[4:0]);
    assign w_hit    = w_h_ok & (w_v_inc >= SIZE6);

    assign w_first_hit = w_hit & ~r_hit_flag;
    assign w_eop       = video_in_valid & video_in_eop;
    assign w_frame_hit = r_hit_flag | w_hit;
    assign w_miss_next = (r_miss == LOST_M) ? r_miss : (r_miss + 1'b1);

    always_ff @(posedge clk) begin
        if (video_in_valid && w_in_range) begin
            r_v_run[w_addr] <= w_v_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_h_run     <= 5'd0;
            r_frame_ok  <= 1'b0;
            r_hit_flag  <= 1'b0;
            r_cand_x    <= 16'd0;
            r_cand_y    <= 16'd0;
            r_miss      <= '0;
            r_pos_x     <= 16'(INIT_X);
            r_pos_y     <= 16'(INIT_Y);
            r_pos_valid <= 1'b0;
            r_hit_pulse <= 1'b0;
        end else begin
            r_hit_pulse <= w_first_hit;
            if (video_in_valid) begin
                r_h_run <= w_h_next;
                if (cnt_x == 16'd0 && cnt_y == 16'd0) begin
                    r_frame_ok <= 1'b1;
                end
            end
            if (w_first_hit) begin
                r_cand_x <= cnt_x;
                r_cand_y <= cnt_y;
            end
            if (w_eop) begin
                r_hit_flag <= 1'b0;
                if (w_frame_hit) begin
                    r_pos_x     <= r_hit_flag ? r_cand_x : cnt_x;
                    r_pos_y     <= r_hit_flag ? r_cand_y : cnt_y;
                    r_pos_valid <= 1'b1;
                    r_miss      <= '0;
                end else begin
                    r_miss <= w_miss_next;
                    if (w_miss_next == LOST_M) begin
                        r_pos_valid <= 1'b0;
                    end
                end
            end else if (w_hit) begin
                r_hit_flag <= 1'b1;
            end
        end
    end

    // 18-bit compares keep the expanded rectangle from wrapping near the origin.
    assign w_x18  = {2'b00, cnt_x};
    assign w_y18  = {2'b00, cnt_y};
    assign w_px18 = {2'b00, r_pos_x};
    assign w_py18 = {2'b00, r_pos_y};

    assign w_outer = (w_x18 + OUT_OFF >= w_px18) & (w_x18 <= w_px18 + BORD18)
                   & (w_y18 + OUT_OFF >= w_py18) & (w_y18 <= w_py18 + BORD18);
    assign w_inner = (w_x18 + IN_OFF >= w_px18) & (w_x18 <= w_px18)
                   & (w_y18 + IN_OFF >= w_py18) & (w_y18 <= w_py18);
    assign w_draw  = r_pos_valid & enable & ((FILL != 0) ? w_outer : (w_outer & ~w_inner));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_det_draw <= 1'b0;
        end else begin
            r_det_draw <= w_draw;
        end
    end

    assign det_draw  = r_det_draw;
    assign pos_x     = r_pos_x;
    assign pos_y     = r_pos_y;
    assign pos_valid = r_pos_valid;
    assign hit_pulse = r_hit_pulse;

endmodule
